// File: rtl/beep_pkg.sv
// Shared types and defaults for the key-triggered buzzer sequencer.
package beep_pkg;

   localparam int BEEP_ON_CYC_DEF    = 5_000_000;
   localparam int BEEP_OFF_CYC_DEF   = 5_000_000;
   localparam int BEEP_TONE_HALF_DEF = 12_500;
   localparam int BEEP_NUM_W         = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } beep_state_t;

   // Timer only ever holds max-1, so clog2(max) bits suffice; never below 1 bit.
   function automatic int beep_tmr_w(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave divider for a passive buzzer: toggles every TONE_HALF cycles while enabled.
// Restart forces the high phase with a fresh count; disabled holds the output low.
module beep_tone_gen
   import beep_pkg::*;
#(
   parameter int TONE_HALF = BEEP_TONE_HALF_DEF
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic en,
   input  logic restart,
   output logic tone
);

   localparam int CNT_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TONE_HALF - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tone;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_cnt  <= '0;
         r_tone <= 1'b0;
      end else if (restart) begin
         r_cnt  <= '0;
         r_tone <= 1'b1;
      end else if (en) begin
         if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt  <= '0;
         r_tone <= 1'b0;
      end
   end

   assign tone = r_tone;

endmodule

// File: rtl/beep_seq_ctrl.sv
// Per key press, plays a burst of beep_num beeps (ON_CYC on, OFF_CYC gap); presses during a burst are dropped.
// Define BEEP_TONE_EN to drive a TONE_HALF square wave during ON instead of a steady level.
module beep_seq_ctrl
   import beep_pkg::*;
#(
   parameter int   ON_CYC      = BEEP_ON_CYC_DEF,
   parameter int   OFF_CYC     = BEEP_OFF_CYC_DEF,
   parameter int   TONE_HALF   = BEEP_TONE_HALF_DEF,
   parameter logic BEEP_ACTIVE = 1'b1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  key_flag,
   input  logic                  key_value,
   input  logic [BEEP_NUM_W-1:0] beep_num,
   output logic                  beep,
   output logic                  busy,
   output logic                  done
);

   localparam int TMR_W = beep_tmr_w(ON_CYC, OFF_CYC);
   localparam logic [TMR_W-1:0] ON_LD  = TMR_W'(ON_CYC - 1);
   localparam logic [TMR_W-1:0] OFF_LD = TMR_W'(OFF_CYC - 1);

   if (ON_CYC < 1 || OFF_CYC < 1 || TONE_HALF < 1) begin : g_param_chk
      $error("beep_seq_ctrl: ON_CYC, OFF_CYC and TONE_HALF must all be >= 1");
   end

   beep_state_t           r_state;
   beep_state_t           w_state_nxt;
   logic [TMR_W-1:0]      r_tmr;
   logic [TMR_W-1:0]      w_tmr_nxt;
   logic [BEEP_NUM_W-1:0] r_rem;
   logic [BEEP_NUM_W-1:0] w_rem_nxt;
   logic                  w_done_nxt;
   logic                  w_press;
   logic                  r_busy;
   logic                  r_done;

   assign w_press = key_flag & ~key_value;

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      w_rem_nxt   = r_rem;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_press && (beep_num != '0)) begin
               w_state_nxt = ON;
               w_tmr_nxt   = ON_LD;
               w_rem_nxt   = beep_num;
            end
         end
         ON: begin
            if (r_tmr == '0) begin
               if (r_rem == BEEP_NUM_W'(1)) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = OFF;
                  w_tmr_nxt   = OFF_LD;
                  w_rem_nxt   = r_rem - 1'b1;
               end
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end
         OFF: begin
            if (r_tmr == '0) begin
               w_state_nxt = ON;
               w_tmr_nxt   = ON_LD;
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state so they line up with the state they describe.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= IDLE;
         r_tmr   <= '0;
         r_rem   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
         r_rem   <= w_rem_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= w_done_nxt;
      end
   end

   assign busy = r_busy;
   assign done = r_done;

`ifdef BEEP_TONE_EN
   logic w_tone;
   logic w_tone_en;
   logic w_tone_restart;

   assign w_tone_en      = (w_state_nxt == ON);
   assign w_tone_restart = (w_state_nxt == ON) && (r_state != ON);

   beep_tone_gen #(
      .TONE_HALF (TONE_HALF)
   ) u_tone_gen (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (w_tone_en),
      .restart (w_tone_restart),
      .tone    (w_tone)
   );

   assign beep = w_tone ? BEEP_ACTIVE : ~BEEP_ACTIVE;
`else
   logic r_beep;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_beep <= ~BEEP_ACTIVE;
      end else begin
         r_beep <= (w_state_nxt == ON) ? BEEP_ACTIVE : ~BEEP_ACTIVE;
      end
   end

   assign beep = r_beep;
`endif

endmodule

// File: tb/tb_beep_seq_ctrl.sv
// Randomized and directed bench for beep_seq_ctrl against a burst-timeline reference model.
module tb_beep_seq_ctrl;

   localparam int   ON_CYC    = 4;
   localparam int   OFF_CYC   = 3;
   localparam int   TONE_HALF = 1;
   localparam logic ACT       = 1'b1;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       key_flag;
   logic       key_value;
   logic [2:0] beep_num;
   logic       beep;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: a burst is fully described by its start edge and beep count.
   bit active = 1'b0;
   int s_edge = 0;
   int s_num  = 0;
   int edge_i = 0;

   always #5 sys_clk = ~sys_clk;

   beep_seq_ctrl #(
      .ON_CYC      (ON_CYC),
      .OFF_CYC     (OFF_CYC),
      .TONE_HALF   (TONE_HALF),
      .BEEP_ACTIVE (ACT)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .key_flag  (key_flag),
      .key_value (key_value),
      .beep_num  (beep_num),
      .beep      (beep),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=%b exp=%b", tag, edge_i, got, exp);
      end
   endtask

   function automatic int burst_len(input int n);
      return n * ON_CYC + (n - 1) * OFF_CYC;
   endfunction

   task automatic step(input bit f, input bit v, input logic [2:0] num, input bit r);
      int  k;
      int  ph;
      bit  on;
      logic e_beep, e_busy, e_done;
      key_flag  = f;
      key_value = v;
      beep_num  = num;
      sys_rst   = r;
      @(posedge sys_clk);
      edge_i++;
      if (r) begin
         active = 1'b0;
      end else if ((!active || (edge_i - s_edge >= burst_len(s_num) + 1)) && f && !v && num != 0) begin
         active = 1'b1;
         s_edge = edge_i;
         s_num  = int'(num);
      end
      on     = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (active) begin
         k = edge_i - s_edge;
         if (k < burst_len(s_num)) begin
            e_busy = 1'b1;
            ph     = k % (ON_CYC + OFF_CYC);
`ifdef BEEP_TONE_EN
            on = (ph < ON_CYC) && (((ph / TONE_HALF) % 2) == 0);
`else
            on = (ph < ON_CYC);
`endif
         end
         e_done = (k == burst_len(s_num));
      end
      e_beep = on ? ACT : ~ACT;
      #1;
      chk("beep", beep, e_beep);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 3'd0, 1'b0);
   endtask

   task automatic press(input logic [2:0] num);
      step(1'b1, 1'b0, num, 1'b0);
   endtask

   initial begin
      key_flag  = 1'b0;
      key_value = 1'b1;
      beep_num  = 3'd0;
      sys_rst   = 1'b1;

      // reset state
      step(1'b0, 1'b1, 3'd0, 1'b1);
      step(1'b1, 1'b0, 3'd3, 1'b1);
      idle(2);

      // single beep, then triple beep
      press(3'd1); idle(8);
      press(3'd3); idle(22);

      // ignored: zero count, release event
      press(3'd0); idle(6);
      step(1'b1, 1'b1, 3'd3, 1'b0); idle(6);

      // press mid-burst leaves burst length unchanged
      press(3'd2); idle(3); press(3'd7); idle(4); press(3'd5); idle(10);

      // reset during second ON phase, then a fresh burst
      press(3'd3); idle(8);
      step(1'b0, 1'b1, 3'd0, 1'b1);
      idle(3);
      press(3'd1); idle(7);

      // press during the done cycle is accepted
      press(3'd1); idle(4); press(3'd2); idle(14);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
              3'($urandom_range(0, 7)), ($urandom_range(0, 199) == 0));
      end
      idle(60);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
